// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: dibit bit positions and combiner phase encoding.
package qpsk_pkg;

   // Bit positions inside a dibit. The splitter and the combiner must agree on these.
   localparam int unsigned I_IDX = 1;
   localparam int unsigned Q_IDX = 0;

   typedef logic [1:0] dibit_t;

   typedef enum logic {
      PHASE0 = 1'b0,
      PHASE1 = 1'b1
   } phase_t;

   // First serial bit of a dibit: I when i_first is set, Q otherwise.
   function automatic logic first_bit(input dibit_t d, input bit i_first);
      return i_first ? d[I_IDX] : d[Q_IDX];
   endfunction

   // Second serial bit of a dibit: the component not sent first.
   function automatic logic second_bit(input dibit_t d, input bit i_first);
      return i_first ? d[Q_IDX] : d[I_IDX];
   endfunction

endpackage

// File: rtl/qpsk_sym_fifo.sv
// Two-bit-wide synchronous symbol FIFO. The occupancy count is the only full/empty source.
module qpsk_sym_fifo
   import qpsk_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  dibit_t                   din,
   input  logic                     pop,
   output dibit_t                   dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   dibit_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage array; contents need no reset since the count marks them invalid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally (power-of-two depth); count tracks push/pop balance.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/qpsk_bit_combiner.sv
// Re-serialises I/Q dibits from the demodulator into a bit stream at the bit-rate strobe.
module qpsk_bit_combiner
   import qpsk_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          I_FIRST    = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sym_valid,
   output logic                          sym_ready,
   input  logic                          sym_i,
   input  logic                          sym_q,
   input  logic                          bit_en,
   output logic                          bit_out,
   output logic                          bit_valid,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   phase_t   phase;
   phase_t   phase_nxt;
   dibit_t   hold;
   dibit_t   sym_in;
   dibit_t   fifo_dout;
   logic     fifo_full;
   logic     fifo_empty;
   logic     push;
   logic     pop;

   always_comb begin
      sym_in        = '0;
      sym_in[I_IDX] = sym_i;
      sym_in[Q_IDX] = sym_q;
   end

   // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
   assign sym_ready = !fifo_full;
   assign push      = sym_valid && sym_ready;

   qpsk_sym_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (sym_in),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Phase state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= PHASE0;
      end else begin
         phase <= phase_nxt;
      end
   end

   // Next phase and FIFO pop: a new dibit is taken only at the start of a dibit slot.
   always_comb begin
      phase_nxt = phase;
      pop       = 1'b0;
      case (phase)
         PHASE0: begin
            if (bit_en && !fifo_empty) begin
               pop       = 1'b1;
               phase_nxt = PHASE1;
            end
         end
         PHASE1: begin
            if (bit_en) begin
               phase_nxt = PHASE0;
            end
         end
         default: phase_nxt = PHASE0;
      endcase
   end

   // Output and hold registers: emit first bit from the FIFO head, second from hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold      <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         bit_valid <= 1'b0;
         underrun  <= 1'b0;
         if (bit_en) begin
            if (phase == PHASE0) begin
               if (!fifo_empty) begin
                  hold      <= fifo_dout;
                  bit_out   <= first_bit(fifo_dout, I_FIRST);
                  bit_valid <= 1'b1;
               end else begin
                  bit_out   <= 1'b0;
                  underrun  <= 1'b1;
               end
            end else begin
               bit_out   <= second_bit(hold, I_FIRST);
               bit_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_qpsk_bit_combiner.sv
// Bench for qpsk_bit_combiner: directed and random steps against a bit-queue model.
module tb_qpsk_bit_combiner;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sym_valid = 1'b0;
   logic       sym_i = 1'b0;
   logic       sym_q = 1'b0;
   logic       bit_en = 1'b0;
   logic       sym_ready_a, sym_ready_b;
   logic       bit_out_a, bit_out_b;
   logic       bit_valid_a, bit_valid_b;
   logic       underrun_a, underrun_b;
   logic [2:0] fifo_count_a, fifo_count_b;

   int total = 0;
   int bad   = 0;

   // Model: bits still to be emitted, in output order, for each bit ordering.
   logic mq_a[$];
   logic mq_b[$];
   logic exp_out_a = 1'b0;
   logic exp_out_b = 1'b0;
   logic last_acc;
   logic got[$];

   always #5 clk = ~clk;

   qpsk_bit_combiner #(.FIFO_DEPTH(DEPTH), .I_FIRST(1'b1)) dut_a (
      .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_ready(sym_ready_a),
      .sym_i(sym_i), .sym_q(sym_q), .bit_en(bit_en), .bit_out(bit_out_a),
      .bit_valid(bit_valid_a), .underrun(underrun_a), .fifo_count(fifo_count_a)
   );

   qpsk_bit_combiner #(.FIFO_DEPTH(DEPTH), .I_FIRST(1'b0)) dut_b (
      .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_ready(sym_ready_b),
      .sym_i(sym_i), .sym_q(sym_q), .bit_en(bit_en), .bit_out(bit_out_b),
      .bit_valid(bit_valid_b), .underrun(underrun_b), .fifo_count(fifo_count_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reset with data and strobe asserted to show reset takes priority.
   task automatic do_reset();
      reset = 1'b1; sym_valid = 1'b1; sym_i = 1'b1; sym_q = 1'b1; bit_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; sym_valid = 1'b0; bit_en = 1'b0;
      mq_a.delete(); mq_b.delete();
      exp_out_a = 1'b0; exp_out_b = 1'b0;
      chk("rst_bit_out",   {31'd0, bit_out_a},   32'd0);
      chk("rst_bit_valid", {31'd0, bit_valid_a}, 32'd0);
      chk("rst_underrun",  {31'd0, underrun_a},  32'd0);
      chk("rst_count",     {29'd0, fifo_count_a}, 32'd0);
      chk("rst_ready",     {31'd0, sym_ready_a}, 32'd1);
      chk("rst_b_out",     {31'd0, bit_out_b},   32'd0);
   endtask

   // One clock: drive inputs, check pre-edge flow control, advance model, check outputs.
   task automatic step(input logic v, input logic i, input logic q, input logic en);
      int   exp_cnt;
      logic exp_ready, acc, exp_valid, exp_und;
      sym_valid = v; sym_i = i; sym_q = q; bit_en = en;
      // A half-emitted dibit sits in the hold register, not the FIFO.
      exp_cnt   = mq_a.size() / 2;
      exp_ready = (exp_cnt != DEPTH);
      chk("count", {29'd0, fifo_count_a}, exp_cnt);
      chk("ready", {31'd0, sym_ready_a},  {31'd0, exp_ready});
      acc = v && exp_ready;
      @(posedge clk); #1;
      exp_valid = 1'b0; exp_und = 1'b0;
      if (en) begin
         if (mq_a.size() > 0) begin
            exp_out_a = mq_a.pop_front();
            exp_out_b = mq_b.pop_front();
            exp_valid = 1'b1;
         end else begin
            exp_out_a = 1'b0; exp_out_b = 1'b0;
            exp_und = 1'b1;
         end
      end
      // Pushes land after the pop decision: a new dibit is not poppable in its own cycle.
      if (acc) begin
         mq_a.push_back(i); mq_a.push_back(q);
         mq_b.push_back(q); mq_b.push_back(i);
      end
      chk("bit_valid", {31'd0, bit_valid_a}, {31'd0, exp_valid});
      chk("underrun",  {31'd0, underrun_a},  {31'd0, exp_und});
      chk("bit_out",   {31'd0, bit_out_a},   {31'd0, exp_out_a});
      chk("bit_out_qf",{31'd0, bit_out_b},   {31'd0, exp_out_b});
      if (bit_valid_a === 1'b1) got.push_back(bit_out_a);
      last_acc = acc;
   endtask

   initial begin
      logic src [64];
      int   guard;

      sym_valid = 1'b0; bit_en = 1'b0;
      #1;
      do_reset();

      // Three dibits then strobe every cycle: 1,0,0,1,1,1 then underruns.
      step(1, 1, 0, 0);
      step(1, 0, 1, 0);
      step(1, 1, 1, 0);
      got.delete();
      for (int n = 0; n < 8; n++) step(0, 0, 0, 1);
      chk("seq_len", got.size(), 6);
      if (got.size() == 6) begin
         chk("seq_val", {26'd0, got[0], got[1], got[2], got[3], got[4], got[5]}, 32'b100111);
      end

      // Same data, strobe every 4th cycle, pushes interleaved with strobes.
      step(1, 1, 0, 1);
      step(1, 0, 1, 0);
      step(1, 1, 1, 0);
      for (int n = 0; n < 24; n++) step(0, 0, 0, (n % 4) == 0);

      // Overfill: five offers with no strobe, then release one dibit.
      for (int n = 0; n < 5; n++) step(1, n[0], n[1], 0);
      chk("full_count", {29'd0, fifo_count_a}, 32'd4);
      chk("full_ready", {31'd0, sym_ready_a},  32'd0);
      step(1, 1, 0, 1);
      step(1, 1, 0, 1);
      chk("refill_count", {29'd0, fifo_count_a}, 32'd4);
      for (int n = 0; n < 12; n++) step(0, 0, 0, 1);

      // Push and PHASE0 pop together at count 2.
      step(1, 1, 0, 0);
      step(1, 0, 1, 0);
      step(1, 1, 1, 1);
      chk("pushpop_count", {29'd0, fifo_count_a}, 32'd2);
      for (int n = 0; n < 8; n++) step(0, 0, 0, 1);

      // Reset mid-dibit: stale second bit of (1,1) must not appear.
      step(1, 1, 1, 0);
      step(0, 0, 0, 1);
      chk("mid_first", {31'd0, bit_out_a}, 32'd1);
      do_reset();
      step(1, 0, 1, 0);
      step(0, 0, 0, 1);
      chk("after_rst_first", {31'd0, bit_out_a}, 32'd0);
      step(0, 0, 0, 1);
      chk("after_rst_second", {31'd0, bit_out_a}, 32'd1);

      // I-first vs Q-first on dibit (1,0).
      step(1, 1, 0, 0);
      step(0, 0, 0, 1);
      chk("qfirst_b0", {31'd0, bit_out_b}, 32'd0);
      step(0, 0, 0, 1);
      chk("qfirst_b1", {31'd0, bit_out_b}, 32'd1);

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 2) != 0);
      end
      for (int n = 0; n < 12; n++) step(0, 0, 0, 1);

      // Loopback: splitter sends bit 2k on I and 2k+1 on Q.
      do_reset();
      got.delete();
      for (int k = 0; k < 64; k++) src[k] = $urandom_range(0, 1);
      for (int k = 0; k < 32; k++) begin
         guard = 0;
         last_acc = 1'b0;
         while (!last_acc && guard < 50) begin
            step(1, src[2*k], src[2*k+1], $urandom_range(0, 1));
            guard++;
         end
         if (!last_acc) chk("loop_accept_timeout", 32'd0, 32'd1);
      end
      for (int n = 0; n < 20; n++) step(0, 0, 0, 1);
      chk("loop_len", got.size(), 64);
      if (got.size() == 64) begin
         for (int k = 0; k < 64; k++) chk("loop_bit", {31'd0, got[k]}, {31'd0, src[k]});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/qpsk_bit_combiner.md
# qpsk_bit_combiner

Receive-side counterpart of the transmit bit splitter: accepts I/Q symbol pairs (dibits) from the demodulator decision stage and re-serialises them into a single bit stream at the bit-rate strobe. A small symbol FIFO decouples the symbol-rate producer from the bit-rate consumer. Output bits are emitted in the same order the splitter consumed them, so splitter followed by combiner is bit-transparent.

## Interface
- FIFO_DEPTH, 4, symbol FIFO depth; power of two, minimum 2
- I_FIRST, 1, 1: emit I bit then Q bit per dibit; 0: Q then I
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- sym_valid  in  1  dibit offered on sym_i/sym_q
- sym_ready  out  1  FIFO can accept; transfer when sym_valid && sym_ready
- sym_i  in  1  in-phase decision bit
- sym_q  in  1  quadrature decision bit
- bit_en  in  1  bit-rate strobe; one output bit slot per high cycle
- bit_out  out  1  serial output bit
- bit_valid  out  1  one-cycle pulse: bit_out carries a new bit
- underrun  out  1  one-cycle pulse: bit slot occurred with no data
- fifo_count  out  $clog2(FIFO_DEPTH)+1  dibits currently stored

## Operation
- Symbol FIFO: write on sym_valid && sym_ready; sym_ready = (fifo_count != FIFO_DEPTH), derived from registered count only (no combinational path from bit_en).
- Phase register `phase` (1 bit), toggling per emitted bit. Holding register `hold` (2 bits) keeps the current dibit.
- PHASE0 (phase=0), bit_en=1:
  - FIFO non-empty: pop head into hold; bit_out <= first bit (I if I_FIRST else Q); bit_valid <= 1; phase <= 1.
  - FIFO empty: bit_out <= 0; bit_valid <= 0; underrun <= 1; phase stays 0.
- PHASE1 (phase=1), bit_en=1: bit_out <= second bit from hold; bit_valid <= 1; phase <= 0. Never underruns (dibit already held).
- bit_en=0: bit_valid <= 0, underrun <= 0, bit_out holds last value, phase unchanged.
- Simultaneous push and pop: both occur; fifo_count unchanged. When full, sym_ready=0 that cycle even if a pop happens; freed slot visible next cycle.
- Pointers wrap modulo FIFO_DEPTH; count is the sole full/empty indicator.

## Timing
- Reset values: bit_out=0, bit_valid=0, underrun=0, fifo_count=0, sym_ready=1, phase=0, hold=0, pointers=0.
- Reset mid-dibit: held partial dibit and all FIFO contents discarded; first bit after reset is always a first-of-dibit bit.
- Latency: dibit accepted at edge N is poppable at edge N+1 (if bit_en and PHASE0); bit_valid observed high after that edge, i.e. 1 cycle after the bit_en cycle.
- Throughput: one dibit per two bit_en strobes; back-to-back bit_en (every cycle) sustained with no bubbles while FIFO non-empty.
- reset has priority over every other input in the same cycle.

## Structure
- Shared package/header qpsk_pkg: dibit bit-index constants (I_IDX=1, Q_IDX=0), used identically by splitter and combiner.
- Sub-module qpsk_sym_fifo: parameterised 2-bit-wide synchronous FIFO (push, pop, dout, count, full, empty); combiner top holds phase/hold/output registers only.

## Test plan
- Reset then push dibits (I,Q) = (1,0),(0,1),(1,1) with bit_en every cycle, I_FIRST=1 -> bit_out sequence 1,0,0,1,1,1 with bit_valid high 6 consecutive cycles, then underrun pulses.
- bit_en every 4th cycle, same data -> same sequence, bit_valid single-cycle pulses 4 cycles apart, no underrun while FIFO non-empty.
- Push 5 dibits with bit_en=0, FIFO_DEPTH=4 -> sym_ready drops after 4th accept, fifo_count=4, 5th held off; one pop (two bit_en) -> sym_ready returns, 5th accepted.
- Push on same cycle as a PHASE0 pop with count=2 -> fifo_count stays 2.
- Assert reset after first bit of dibit (1,1) -> next bit after refill is first bit of new dibit (0,1) -> 0, not stale 1; all outputs at reset values.
- I_FIRST=0, dibit (1,0) -> bit_out 0 then 1; splitter-to-combiner loopback of 64 random bits -> identical stream.
